// File: rtl/kinematics_fwd_engine.sv
// Forward kinematics for a four-wheel mecanum base: wheel rates -> body vx, vy, wz.
// Start/done handshake, one shared signed multiplier, round-half-up, saturation with per-output flags.
module kinematics_fwd_engine #(
    parameter int                        N_WIDTH = 32,
    parameter int                        Q_WIDTH = 15,
    parameter logic signed [N_WIDTH-1:0] K_VXY   = N_WIDTH'(298),
    parameter logic signed [N_WIDTH-1:0] K_WZ    = N_WIDTH'(747)
) (
    input  logic               KINEMATICS_FWD_CLOCK_50,
    input  logic               KINEMATICS_FWD_Reset_InHigh,
    input  logic               KINEMATICS_FWD_start_InHigh,
    input  logic [N_WIDTH-1:0] KINEMATICS_FWD_W1_InBus,
    input  logic [N_WIDTH-1:0] KINEMATICS_FWD_W2_InBus,
    input  logic [N_WIDTH-1:0] KINEMATICS_FWD_W3_InBus,
    input  logic [N_WIDTH-1:0] KINEMATICS_FWD_W4_InBus,
    output logic [N_WIDTH-1:0] KINEMATICS_FWD_VX_OutBus,
    output logic [N_WIDTH-1:0] KINEMATICS_FWD_VY_OutBus,
    output logic [N_WIDTH-1:0] KINEMATICS_FWD_WZ_OutBus,
    output logic [2:0]         KINEMATICS_FWD_ovf_OutBus,
    output logic               KINEMATICS_FWD_busy_OutHigh,
    output logic               KINEMATICS_FWD_done_OutHigh
);

    localparam int SW = N_WIDTH + 2;
    localparam int PW = 2 * N_WIDTH + 3;

    localparam logic signed [PW-1:0] ROUND_C = PW'(1) <<< (Q_WIDTH - 1);
    localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (N_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (N_WIDTH - 1));

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        MUL_VX,
        MUL_VY,
        MUL_WZ,
        DONE
    } state_t;

    state_t state;

    logic signed [N_WIDTH-1:0] w1_q, w2_q, w3_q, w4_q;
    logic signed [SW-1:0]      sum_vx, sum_vy, sum_wz;
    logic [N_WIDTH-1:0]        sh_vx, sh_vy, sh_wz;
    logic [2:0]                sh_ovf;

    logic signed [SW-1:0]      mul_a;
    logic signed [N_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]      product, rounded, shifted;
    logic [N_WIDTH-1:0]        sat_val;
    logic                      sat_ovf;
    logic                      accept;

    assign accept = KINEMATICS_FWD_start_InHigh && (state == IDLE || state == DONE);

    // Single multiplier; operand selection follows the MUL_* state.
    always_comb begin
        mul_a = sum_vx;
        mul_b = K_VXY;
        case (state)
            MUL_VY: mul_a = sum_vy;
            MUL_WZ: begin
                mul_a = sum_wz;
                mul_b = K_WZ;
            end
            default: ;
        endcase
        product = PW'(mul_a) * PW'(mul_b);
        rounded = product + ROUND_C;
        shifted = rounded >>> Q_WIDTH;
        sat_val = shifted[N_WIDTH-1:0];
        sat_ovf = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_val = {1'b0, {(N_WIDTH-1){1'b1}}};
            sat_ovf = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val = {1'b1, {(N_WIDTH-1){1'b0}}};
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge KINEMATICS_FWD_CLOCK_50 or posedge KINEMATICS_FWD_Reset_InHigh) begin
        if (KINEMATICS_FWD_Reset_InHigh) begin
            state                       <= IDLE;
            w1_q                        <= '0;
            w2_q                        <= '0;
            w3_q                        <= '0;
            w4_q                        <= '0;
            sum_vx                      <= '0;
            sum_vy                      <= '0;
            sum_wz                      <= '0;
            sh_vx                       <= '0;
            sh_vy                       <= '0;
            sh_wz                       <= '0;
            sh_ovf                      <= '0;
            KINEMATICS_FWD_VX_OutBus    <= '0;
            KINEMATICS_FWD_VY_OutBus    <= '0;
            KINEMATICS_FWD_WZ_OutBus    <= '0;
            KINEMATICS_FWD_ovf_OutBus   <= '0;
            KINEMATICS_FWD_busy_OutHigh <= 1'b0;
            KINEMATICS_FWD_done_OutHigh <= 1'b0;
        end else begin
            KINEMATICS_FWD_done_OutHigh <= 1'b0;
            // busy lags the state by one edge so it spans SUM-entry+1 through the done cycle.
            KINEMATICS_FWD_busy_OutHigh <= (state != IDLE);

            if (accept) begin
                w1_q <= $signed(KINEMATICS_FWD_W1_InBus);
                w2_q <= $signed(KINEMATICS_FWD_W2_InBus);
                w3_q <= $signed(KINEMATICS_FWD_W3_InBus);
                w4_q <= $signed(KINEMATICS_FWD_W4_InBus);
            end

            case (state)
                IDLE: begin
                    if (accept) state <= SUM;
                end
                SUM: begin
                    sum_vx <= SW'(w1_q) + SW'(w2_q) + SW'(w3_q) + SW'(w4_q);
                    sum_vy <= SW'(w2_q) + SW'(w3_q) - SW'(w1_q) - SW'(w4_q);
                    sum_wz <= SW'(w2_q) + SW'(w4_q) - SW'(w1_q) - SW'(w3_q);
                    state  <= MUL_VX;
                end
                MUL_VX: begin
                    sh_vx     <= sat_val;
                    sh_ovf[0] <= sat_ovf;
                    state     <= MUL_VY;
                end
                MUL_VY: begin
                    sh_vy     <= sat_val;
                    sh_ovf[1] <= sat_ovf;
                    state     <= MUL_WZ;
                end
                MUL_WZ: begin
                    sh_wz     <= sat_val;
                    sh_ovf[2] <= sat_ovf;
                    state     <= DONE;
                end
                DONE: begin
                    KINEMATICS_FWD_VX_OutBus    <= sh_vx;
                    KINEMATICS_FWD_VY_OutBus    <= sh_vy;
                    KINEMATICS_FWD_WZ_OutBus    <= sh_wz;
                    KINEMATICS_FWD_ovf_OutBus   <= sh_ovf;
                    KINEMATICS_FWD_done_OutHigh <= 1'b1;
                    state                       <= accept ? SUM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
